// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
//   Command-decoding byte RAM controller fed by an SPI slave receive bus.
//   Each 10-bit frame carries a command in din[9:8] and an address or data
//   byte in din[7:0]:
//     00 write-address, 01 write-data, 10 read-address, 11 read-data.
//   Read data is returned on dout together with a one-cycle tx_valid pulse.
//   Rejected frames (out-of-sequence data, out-of-range address) give a
//   one-cycle cmd_err pulse and change nothing else.
//
// Optional build macro:
//   RAM_AUTO_INC_EN - post-increment wr_addr/rd_addr (wrapping at
//                     MEM_DEPTH-1) after every accepted write-data/read-data.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   din       in  10   frame: [9:8] command, [7:0] payload
//   rx_valid  in   1   din valid this cycle
//   dout      out  8   read data byte (held until the next accepted read)
//   tx_valid  out  1   dout freshly loaded
//   cmd_err   out  1   frame rejected
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WADDR,
    ST_RADDR
  } state_t;

  // 9-bit limit so MEM_DEPTH = 256 compares correctly against an 8-bit payload.
  localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);
`ifdef RAM_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic [1:0] w_cmd;
  logic [7:0] w_payload;
  logic       w_in_range;
  logic       w_wr_addr_ld;
  logic       w_rd_addr_ld;
  logic       w_mem_we;
  logic       w_rd_en;
  logic       w_err;

  assign w_cmd      = din[9:8];
  assign w_payload  = din[7:0];
  assign w_in_range = {1'b0, w_payload} < DEPTH_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decode is gated by rst so a frame presented during reset is discarded,
  // including the (unreset) memory write.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_addr_ld = 1'b0;
    w_rd_addr_ld = 1'b0;
    w_mem_we     = 1'b0;
    w_rd_en      = 1'b0;
    w_err        = 1'b0;
    if (rx_valid && !rst) begin
      unique case (w_cmd)
        2'b00: begin
          if (w_in_range) begin
            w_wr_addr_ld = 1'b1;
            w_state_nxt  = ST_WADDR;
          end else begin
            w_err = 1'b1;
          end
        end
        2'b10: begin
          if (w_in_range) begin
            w_rd_addr_ld = 1'b1;
            w_state_nxt  = ST_RADDR;
          end else begin
            w_err = 1'b1;
          end
        end
        2'b01: begin
          if (r_state == ST_WADDR) begin
            w_mem_we = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          if (r_state == ST_RADDR) begin
            w_rd_en = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      dout      <= '0;
      tx_valid  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      tx_valid <= w_rd_en;
      cmd_err  <= w_err;
      if (w_rd_en) begin
        dout <= r_mem[r_rd_addr];
      end
      if (w_wr_addr_ld) begin
        r_wr_addr <= ADDR_SIZE'(w_payload);
      end
      if (w_rd_addr_ld) begin
        r_rd_addr <= ADDR_SIZE'(w_payload);
      end
`ifdef RAM_AUTO_INC_EN
      if (w_mem_we) begin
        r_wr_addr <= (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;

  // index 0: default 256-entry instance, index 1: 200-entry instance
  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, err_a, err_b;

  int checks   = 0;
  int failures = 0;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_a), .tx_valid(tx_a), .cmd_err(err_a)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_d200 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout_b), .tx_valid(tx_b), .cmd_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  // Reference model: mode 0 = idle, 1 = write address set, 2 = read address set.
  int         m_depth [2] = '{256, 200};
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  int         m_wr    [2];
  int         m_rd    [2];
  int         m_mode  [2];
  logic [7:0] e_dout  [2];
  bit         e_dknown[2];
  bit         e_tx    [2];
  bit         e_err   [2];

  function automatic void model_step(int k, bit r, bit v, logic [9:0] f);
    int cmd;
    int pl;
    cmd = int'(f[9:8]);
    pl  = int'(f[7:0]);
    e_tx[k]  = 0;
    e_err[k] = 0;
    if (r) begin
      m_wr[k] = 0; m_rd[k] = 0; m_mode[k] = 0;
      e_dout[k] = 8'h00; e_dknown[k] = 1;
    end else if (v) begin
      if (cmd == 0 || cmd == 2) begin
        if (pl >= m_depth[k]) e_err[k] = 1;
        else if (cmd == 0) begin m_wr[k] = pl; m_mode[k] = 1; end
        else begin m_rd[k] = pl; m_mode[k] = 2; end
      end else if (cmd == 1) begin
        if (m_mode[k] != 1) e_err[k] = 1;
        else begin
          m_mem[k][m_wr[k]]   = f[7:0];
          m_known[k][m_wr[k]] = 1;
          if (AUTO_INC) m_wr[k] = (m_wr[k] + 1) % m_depth[k];
        end
      end else begin
        if (m_mode[k] != 2) e_err[k] = 1;
        else begin
          e_dout[k]   = m_mem[k][m_rd[k]];
          e_dknown[k] = m_known[k][m_rd[k]];
          e_tx[k]     = 1;
          if (AUTO_INC) m_rd[k] = (m_rd[k] + 1) % m_depth[k];
        end
      end
    end
  endfunction

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input bit r, input bit v, input logic [9:0] f);
    rst = r; rx_valid = v; din = f;
    @(posedge clk);
    #1;
    model_step(0, r, v, f);
    model_step(1, r, v, f);
    rst = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1, 0, 10'h000);
    cycle(0, 1, 10'h0AA);
    cycle(0, 1, 10'h155);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 10'h1AA);
      checks++;
      if (dout_a !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout_a); end
      checks++;
      if (tx_a !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b exp=0", tx_a); end
      checks++;
      if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_a); end
    end
    cycle(0, 1, 10'h2AA);
    cycle(0, 1, 10'h300);
    checks++;
    if (tx_a !== 1'b1 || dout_a !== 8'h55)
      begin failures++; $display("FAIL reset_no_write got=%b/%h exp=1/55", tx_a, dout_a); end
  endtask

  task automatic test_write_read;
    cycle(0, 1, 10'h005);
    cycle(0, 1, 10'h1A5);
    cycle(0, 1, 10'h205);
    checks++;
    if (tx_a !== 1'b0) begin failures++; $display("FAIL wr_early_tx got=%b exp=0", tx_a); end
    cycle(0, 1, 10'h300);
    checks++;
    if (tx_a !== 1'b1 || dout_a !== 8'hA5)
      begin failures++; $display("FAIL wr_read got=%b/%h exp=1/a5", tx_a, dout_a); end
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 10'h000);
      checks++;
      if (tx_a !== 1'b0 || dout_a !== 8'hA5)
        begin failures++; $display("FAIL wr_hold[%0d] got=%b/%h exp=0/a5", i, tx_a, dout_a); end
    end
  endtask

  task automatic test_seq_error;
    cycle(1, 0, 10'h000);
    cycle(0, 1, 10'h1FF);
    checks++;
    if (err_a !== 1'b1 || tx_a !== 1'b0)
      begin failures++; $display("FAIL seq_wdata got=%b/%b exp=1/0", err_a, tx_a); end
    cycle(0, 1, 10'h300);
    checks++;
    if (err_a !== 1'b1 || tx_a !== 1'b0 || dout_a !== 8'h00)
      begin failures++; $display("FAIL seq_rdata got=%b/%b/%h exp=1/0/00", err_a, tx_a, dout_a); end
    cycle(0, 0, 10'h000);
    checks++;
    if (err_a !== 1'b0 || tx_a !== 1'b0)
      begin failures++; $display("FAIL seq_clear got=%b/%b exp=0/0", err_a, tx_a); end
  endtask

  task automatic test_range;
    cycle(1, 0, 10'h000);
    cycle(0, 1, 10'h0C8);
    checks++;
    if (err_b !== 1'b1) begin failures++; $display("FAIL range_d200 got=%b exp=1", err_b); end
    checks++;
    if (err_a !== 1'b0) begin failures++; $display("FAIL range_d256 got=%b exp=0", err_a); end
    cycle(0, 1, 10'h177);
    checks++;
    if (err_b !== 1'b1) begin failures++; $display("FAIL range_idle_d200 got=%b exp=1", err_b); end
    checks++;
    if (err_a !== 1'b0) begin failures++; $display("FAIL range_wr_d256 got=%b exp=0", err_a); end
  endtask

  task automatic test_auto_inc;
    logic [7:0] exp1;
    exp1 = AUTO_INC ? 8'h11 : 8'h22;
    cycle(0, 1, 10'h0FF);
    cycle(0, 1, 10'h111);
    cycle(0, 1, 10'h122);
    cycle(0, 1, 10'h2FF);
    cycle(0, 1, 10'h300);
    checks++;
    if (tx_a !== 1'b1 || dout_a !== exp1)
      begin failures++; $display("FAIL autoinc_rd1 got=%b/%h exp=1/%h", tx_a, dout_a, exp1); end
    cycle(0, 1, 10'h300);
    checks++;
    if (tx_a !== 1'b1 || dout_a !== 8'h22)
      begin failures++; $display("FAIL autoinc_rd2 got=%b/%h exp=1/22", tx_a, dout_a); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] fr [4];
    fr = '{10'h010, 10'h133, 10'h210, 10'h300};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, fr[i]);
      if (i < 3) begin
        checks++;
        if (tx_a !== 1'b0 || err_a !== 1'b0)
          begin failures++; $display("FAIL b2b_cyc%0d got=%b/%b exp=0/0", i, tx_a, err_a); end
      end
    end
    checks++;
    if (tx_a !== 1'b1 || dout_a !== 8'h33)
      begin failures++; $display("FAIL b2b_read got=%b/%h exp=1/33", tx_a, dout_a); end
  endtask

  task automatic test_reset_mid_read;
    cycle(0, 1, 10'h210);
    cycle(1, 1, 10'h300);
    checks++;
    if (tx_a !== 1'b0 || dout_a !== 8'h00)
      begin failures++; $display("FAIL rst_mid_read got=%b/%h exp=0/00", tx_a, dout_a); end
  endtask

  task automatic test_random;
    logic [9:0] f;
    bit         v, r;
    for (int n = 0; n < 400; n++) begin
      f[9:8] = 2'($urandom_range(0, 3));
      f[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(190, 209));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 59) == 0);
      cycle(r, v, f);
      checks++;
      if (tx_a !== e_tx[0] || err_a !== e_err[0])
        begin failures++; $display("FAIL rand_a_flags n=%0d got=%b/%b exp=%b/%b", n, tx_a, err_a, e_tx[0], e_err[0]); end
      checks++;
      if (tx_b !== e_tx[1] || err_b !== e_err[1])
        begin failures++; $display("FAIL rand_b_flags n=%0d got=%b/%b exp=%b/%b", n, tx_b, err_b, e_tx[1], e_err[1]); end
      if (e_dknown[0]) begin
        checks++;
        if (dout_a !== e_dout[0])
          begin failures++; $display("FAIL rand_a_dout n=%0d got=%h exp=%h", n, dout_a, e_dout[0]); end
      end
      if (e_dknown[1]) begin
        checks++;
        if (dout_b !== e_dout[1])
          begin failures++; $display("FAIL rand_b_dout n=%0d got=%h exp=%h", n, dout_b, e_dout[1]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; rx_valid = 1'b0; din = '0;
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_rd[k] = 0; m_mode[k] = 0;
      e_dout[k] = 8'h00; e_dknown[k] = 0; e_tx[k] = 0; e_err[k] = 0;
      for (int a = 0; a < 256; a++) begin
        m_known[k][a] = 0;
        m_mem[k][a]   = 8'h00;
      end
    end
    test_reset;
    test_write_read;
    test_seq_error;
    test_range;
    test_auto_inc;
    test_back_to_back;
    test_reset_mid_read;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
